// File: rtl/inst_aligner.sv
// Instruction aligner: repacks 32-bit fetch words into whole RVC/RV32 instructions
// using a 3-halfword FIFO whose occupancy is the FSM state.
module inst_aligner #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_word_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_ready_o,
    output logic            dec_valid_o,
    output logic [XLEN-1:0] dec_inst_o,
    output logic            dec_is_cmp_o,
    output logic [XLEN-1:0] dec_pc_o,
    input  logic            dec_ready_i,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_hw [3];
    logic [15:0]     w_hw_nxt [3];
    logic [15:0]     w_shift [3];
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;

    logic            w_head_cmp;
    logic            w_accept;
    logic            w_consume;
    logic [1:0]      w_cons;
    logic [1:0]      w_add;
    logic [2:0]      w_rem;
    logic [1:0]      w_cnt_nxt;
    logic [15:0]     w_app0;
    logic [15:0]     w_app1;

    // Handshake: a word moves on fetch_valid_i & fetch_ready_o, an instruction
    // on dec_valid_o & dec_ready_i; flush_i suppresses both in its cycle.
    assign w_head_cmp    = (r_hw[0][1:0] != 2'b11);
    assign fetch_ready_o = (r_state == S0) || (r_state == S1);
    assign dec_valid_o   = ((r_state != S0) && w_head_cmp) ||
                           (((r_state == S2) || (r_state == S3)) && !w_head_cmp);
    assign dec_is_cmp_o  = (r_state != S0) && w_head_cmp;
    assign dec_inst_o    = w_head_cmp ? {16'h0, r_hw[0]} : {r_hw[1], r_hw[0]};
    assign dec_pc_o      = r_pc;
    assign dbg_state_o   = r_state;

    assign w_accept  = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign w_consume = dec_valid_o & dec_ready_i & ~flush_i;
    assign w_app0    = fetch_pc_i[1] ? fetch_word_i[31:16] : fetch_word_i[15:0];
    assign w_app1    = fetch_word_i[31:16];

    always_comb begin
        w_cons = 2'd0;
        if (w_consume) begin
            w_cons = w_head_cmp ? 2'd1 : 2'd2;
        end
        w_add = 2'd0;
        if (w_accept) begin
            w_add = fetch_pc_i[1] ? 2'd1 : 2'd2;
        end
        w_rem     = {1'b0, r_state} - {1'b0, w_cons};
        w_cnt_nxt = w_rem[1:0] + w_add;

        case (w_cons)
            2'd1: begin
                w_shift[0] = r_hw[1];
                w_shift[1] = r_hw[2];
                w_shift[2] = 16'h0;
            end
            2'd2: begin
                w_shift[0] = r_hw[2];
                w_shift[1] = 16'h0;
                w_shift[2] = 16'h0;
            end
            default: begin
                w_shift[0] = r_hw[0];
                w_shift[1] = r_hw[1];
                w_shift[2] = r_hw[2];
            end
        endcase

        // Survivors keep their order; new halfwords land right behind them.
        for (int i = 0; i < 3; i++) begin
            if (3'(i) < w_rem) begin
                w_hw_nxt[i] = w_shift[i];
            end else if ((w_add != 2'd0) && (3'(i) == w_rem)) begin
                w_hw_nxt[i] = w_app0;
            end else if ((w_add == 2'd2) && (3'(i) == w_rem + 3'd1)) begin
                w_hw_nxt[i] = w_app1;
            end else begin
                w_hw_nxt[i] = 16'h0;
            end
        end

        w_state_nxt = state_t'(w_cnt_nxt);
        w_pc_nxt    = r_pc;
        if (w_accept && (r_state == S0)) begin
            w_pc_nxt = fetch_pc_i;
        end else if (w_consume) begin
            w_pc_nxt = r_pc + (w_head_cmp ? XLEN'(2) : XLEN'(4));
        end

        if (flush_i) begin
            w_state_nxt = S0;
            w_pc_nxt    = '0;
            for (int i = 0; i < 3; i++) begin
                w_hw_nxt[i] = 16'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
            r_pc    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_hw[i] <= 16'h0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            for (int i = 0; i < 3; i++) begin
                r_hw[i] <= w_hw_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Bench for inst_aligner: directed vector table, hand-written corner sequences
// and random traffic checked against a halfword-queue reference model.
module tb_inst_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_word_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        dec_valid_o;
    logic [31:0] dec_inst_o;
    logic        dec_is_cmp_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;
    logic [1:0]  dbg_state_o;

    inst_aligner #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fetch_valid_i(fetch_valid_i),
        .fetch_word_i (fetch_word_i),
        .fetch_pc_i   (fetch_pc_i),
        .fetch_ready_o(fetch_ready_o),
        .dec_valid_o  (dec_valid_o),
        .dec_inst_o   (dec_inst_o),
        .dec_is_cmp_o (dec_is_cmp_o),
        .dec_pc_o     (dec_pc_o),
        .dec_ready_i  (dec_ready_i),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered halfwords in program order plus head address.
    logic [15:0] exp_q[$];
    logic [31:0] m_pc;

    typedef struct {
        bit          fv;
        logic [31:0] word;
        logic [31:0] pc;
        bit          dr;
        bit          e_valid;
        bit          e_fready;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        bit          e_cmp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit m_cmp();
        return (exp_q.size() > 0) && (exp_q[0][1:0] != 2'b11);
    endfunction

    function automatic bit m_valid();
        if (exp_q.size() == 0) return 1'b0;
        if (exp_q[0][1:0] != 2'b11) return 1'b1;
        return exp_q.size() >= 2;
    endfunction

    function automatic logic [31:0] m_inst();
        if (m_cmp()) return {16'h0, exp_q[0]};
        return {exp_q[1], exp_q[0]};
    endfunction

    task automatic model_check();
        check("state", 32'(dbg_state_o), 32'(exp_q.size()));
        check("fetch_ready", 32'(fetch_ready_o), 32'(exp_q.size() <= 1));
        check("dec_valid", 32'(dec_valid_o), 32'(m_valid()));
        if (m_valid()) begin
            check("dec_inst", dec_inst_o, m_inst());
            check("dec_pc", dec_pc_o, m_pc);
            check("dec_is_cmp", 32'(dec_is_cmp_o), 32'(m_cmp()));
        end
    endtask

    task automatic model_update(input bit fl, input bit fv, input logic [31:0] word,
                                input logic [31:0] pc, input bit dr);
        int  pre;
        bit  acc;
        bit  con;
        if (fl) begin
            exp_q.delete();
            m_pc = 32'h0;
            return;
        end
        pre = exp_q.size();
        acc = fv && (pre <= 1);
        con = m_valid() && dr;
        if (con) begin
            if (m_cmp()) begin
                void'(exp_q.pop_front());
                m_pc = m_pc + 32'd2;
            end else begin
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                m_pc = m_pc + 32'd4;
            end
        end
        if (acc) begin
            if (pre == 0) m_pc = pc;
            if (!pc[1]) exp_q.push_back(word[15:0]);
            exp_q.push_back(word[31:16]);
        end
    endtask

    // Driver: entered and left at posedge+1, where registered outputs are stable.
    task automatic step(input bit fl, input bit fv, input logic [31:0] word,
                        input logic [31:0] pc, input bit dr);
        model_check();
        flush_i       = fl;
        fetch_valid_i = fv;
        fetch_word_i  = word;
        fetch_pc_i    = pc;
        dec_ready_i   = dr;
        model_update(fl, fv, word, pc, dr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit dr);
        step(1'b0, 1'b0, 32'h0, 32'h0, dr);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] p;

        rst           = 1'b1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_word_i  = 32'h0;
        fetch_pc_i    = 32'h0;
        dec_ready_i   = 1'b0;
        m_pc          = 32'h0;

        #3;
        check("rst_valid", 32'(dec_valid_o), 32'd0);
        check("rst_fready", 32'(fetch_ready_o), 32'd1);
        check("rst_inst", dec_inst_o, 32'h0);
        check("rst_cmp", 32'(dec_is_cmp_o), 32'd0);
        check("rst_pc", dec_pc_o, 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two compressed instructions, then a 32-bit one split across words.
        tbl[0] = '{1'b1, 32'h4501_4505, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_4505, 32'h8000_0000, 1'b1};
        tbl[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h8000_0002, 1'b1};
        tbl[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[4] = '{1'b1, 32'h0093_4505, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_4505, 32'h8000_0000, 1'b1};
        tbl[6] = '{1'b1, 32'h0000_0050, 32'h8000_0004, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[7] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0050_0093, 32'h8000_0002, 1'b0};
        tbl[8] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_0006, 1'b1};
        tbl[9] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            check($sformatf("tbl%0d_valid", i), 32'(dec_valid_o), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_fready", i), 32'(fetch_ready_o), 32'(tbl[i].e_fready));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_inst", i), dec_inst_o, tbl[i].e_inst);
                check($sformatf("tbl%0d_pc", i), dec_pc_o, tbl[i].e_pc);
                check($sformatf("tbl%0d_cmp", i), 32'(dec_is_cmp_o), 32'(tbl[i].e_cmp));
            end
            step(1'b0, tbl[i].fv, tbl[i].word, tbl[i].pc, tbl[i].dr);
        end

        // Flush while full, with a fetch word offered in the flush cycle.
        step(1'b0, 1'b1, 32'h1111_4505, 32'h8000_00FE, 1'b0);
        step(1'b0, 1'b1, 32'h2222_4444, 32'h8000_0100, 1'b0);
        check("fl_state_full", 32'(dbg_state_o), 32'd3);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h8000_0104, 1'b0);
        check("fl_state", 32'(dbg_state_o), 32'd0);
        check("fl_valid", 32'(dec_valid_o), 32'd0);
        check("fl_fready", 32'(fetch_ready_o), 32'd1);
        step(1'b0, 1'b1, 32'h0001_4505, 32'h8000_0102, 1'b1);
        check("fl_inst", dec_inst_o, 32'h0000_0001);
        check("fl_pc", dec_pc_o, 32'h8000_0102);
        check("fl_cmp", 32'(dec_is_cmp_o), 32'd1);
        idle(1'b1);

        // Reset pulse between edges while holding two halfwords.
        step(1'b0, 1'b1, 32'h4501_4503, 32'h8000_0200, 1'b0);
        check("rm_state_pre", 32'(dbg_state_o), 32'd2);
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rm_valid", 32'(dec_valid_o), 32'd0);
        check("rm_fready", 32'(fetch_ready_o), 32'd1);
        check("rm_state", 32'(dbg_state_o), 32'd0);
        exp_q.delete();
        m_pc = 32'h0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rm_valid_after", 32'(dec_valid_o), 32'd0);
        step(1'b0, 1'b1, 32'h0000_4509, 32'h8000_0300, 1'b1);
        check("rm_new_inst", dec_inst_o, 32'h0000_4509);
        check("rm_new_pc", dec_pc_o, 32'h8000_0300);
        idle(1'b1);
        idle(1'b1);

        // Head PC wraps through zero.
        step(1'b0, 1'b1, 32'h4501_4505, 32'hFFFF_FFFE, 1'b1);
        check("wr_inst0", dec_inst_o, 32'h0000_4501);
        check("wr_pc0", dec_pc_o, 32'hFFFF_FFFE);
        step(1'b0, 1'b1, 32'h0000_4505, 32'h0000_0000, 1'b1);
        check("wr_inst1", dec_inst_o, 32'h0000_4505);
        check("wr_pc1", dec_pc_o, 32'h0000_0000);
        repeat (3) idle(1'b1);

        // Backpressure with a continuous fetch stream, then drain.
        p = 32'h8000_0400;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            step(1'b0, 1'b1, w, p, 1'b0);
            p = p + 32'd4;
        end
        check("bp_fready", 32'(fetch_ready_o), 32'd0);
        check("bp_state_ge2", 32'(dbg_state_o >= 2'd2), 32'd1);
        repeat (6) idle(1'b1);
        check("bp_drained", 32'(dbg_state_o), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
            p = $urandom;
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), w, p,
                 ($urandom_range(0, 3) != 0));
        end
        model_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
